pipeline_hazard_unit: RTL and testbench

//  Hazard and forwarding control for the 5-stage RV32I pipeline (IF/ID/EX/MEM/WB).

---
 rtl/pipeline_hazard_unit.sv | 137 +++++++++++++
 tb/tb_pipeline_hazard_unit.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_unit.sv
// Hazard and forwarding control for a 5-stage RV32I pipeline. Tracks in-flight
// destination registers, inserts load-use bubbles, drives ALU forwarding selects,
// raises flush strobes on a taken branch and keeps saturating event counters.
module pipeline_hazard_unit #(
   parameter int unsigned REG_ADDR_W      = 5,
   parameter int unsigned LOAD_USE_STALLS = 1,
   parameter int unsigned CNT_W           = 16
) (
   input  logic                  CLK,
   input  logic                  RESET_N,
   input  logic                  id_valid,
   input  logic [REG_ADDR_W-1:0] id_rs1,
   input  logic [REG_ADDR_W-1:0] id_rs2,
   input  logic                  id_uses_rs1,
   input  logic                  id_uses_rs2,
   input  logic [REG_ADDR_W-1:0] id_rd,
   input  logic                  id_reg_write,
   input  logic                  id_mem_read,
   input  logic                  ex_branch_taken,
   output logic                  stall_if,
   output logic                  bubble_ex,
   output logic                  flush_if_id,
   output logic                  flush_id_ex,
   output logic [1:0]            fwd_a_sel,
   output logic [1:0]            fwd_b_sel,
   output logic [CNT_W-1:0]      stall_cycles,
   output logic [CNT_W-1:0]      flush_events
);

   // The counter holds the stall cycles still owed after the detecting cycle,
   // so a load-use hit costs exactly LOAD_USE_STALLS bubbles in total.
   localparam int unsigned StallW = (LOAD_USE_STALLS > 1) ? $clog2(LOAD_USE_STALLS) : 1;
   localparam logic [StallW-1:0] StallLoad = StallW'(LOAD_USE_STALLS - 1);

   // EX and MEM scoreboard slots. A WB-stage writer is visible through the
   // write-before-read register file, so nothing past MEM needs to be kept.
   logic                  ex_vld_q, ex_rw_q, ex_mr_q;
   logic [REG_ADDR_W-1:0] ex_rd_q;
   logic                  mem_vld_q, mem_rw_q;
   logic [REG_ADDR_W-1:0] mem_rd_q;

   logic [StallW-1:0] stall_cnt_q, stall_cnt_d;
   logic [1:0]        fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;
   logic [CNT_W-1:0]  stall_cycles_q, stall_cycles_d;
   logic [CNT_W-1:0]  flush_events_q, flush_events_d;

   logic ex_hit_a, ex_hit_b, mem_hit_a, mem_hit_b;
   logic load_use, stall, advance;

   function automatic logic reg_hit(input logic vld, input logic rw,
                                    input logic [REG_ADDR_W-1:0] rd,
                                    input logic [REG_ADDR_W-1:0] rs, input logic uses);
      return vld & rw & (rd != '0) & (rd == rs) & uses;
   endfunction

   // Hazard detection: operand matches, load-use and stall/advance decisions.
   always_comb begin
      ex_hit_a  = reg_hit(ex_vld_q, ex_rw_q, ex_rd_q, id_rs1, id_uses_rs1);
      ex_hit_b  = reg_hit(ex_vld_q, ex_rw_q, ex_rd_q, id_rs2, id_uses_rs2);
      mem_hit_a = reg_hit(mem_vld_q, mem_rw_q, mem_rd_q, id_rs1, id_uses_rs1);
      mem_hit_b = reg_hit(mem_vld_q, mem_rw_q, mem_rd_q, id_rs2, id_uses_rs2);
      // An empty ID slot has meaningless source fields and must not stall.
      load_use  = id_valid & ex_mr_q & (ex_hit_a | ex_hit_b) & (stall_cnt_q == '0);
      stall     = ~ex_branch_taken & ((stall_cnt_q != '0) | load_use);
      advance   = id_valid & ~stall & ~ex_branch_taken;
   end

   // Next-state for the stall counter, forwarding selects and event counters.
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (ex_branch_taken) begin
         stall_cnt_d = '0;
      end else if (load_use) begin
         stall_cnt_d = StallLoad;
      end else if (stall_cnt_q != '0) begin
         stall_cnt_d = stall_cnt_q - 1'b1;
      end

      fwd_a_d = 2'd0;
      fwd_b_d = 2'd0;
      if (advance) begin
         if (ex_hit_a)       fwd_a_d = 2'd1;
         else if (mem_hit_a) fwd_a_d = 2'd2;
         if (ex_hit_b)       fwd_b_d = 2'd1;
         else if (mem_hit_b) fwd_b_d = 2'd2;
      end

      stall_cycles_d = stall_cycles_q;
      if (stall && (stall_cycles_q != '1)) stall_cycles_d = stall_cycles_q + 1'b1;
      flush_events_d = flush_events_q;
      if (ex_branch_taken && (flush_events_q != '1)) flush_events_d = flush_events_q + 1'b1;
   end

   // State registers; the scoreboard shifts every cycle since the back end never stalls.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         ex_vld_q       <= 1'b0;
         ex_rw_q        <= 1'b0;
         ex_mr_q        <= 1'b0;
         ex_rd_q        <= '0;
         mem_vld_q      <= 1'b0;
         mem_rw_q       <= 1'b0;
         mem_rd_q       <= '0;
         stall_cnt_q    <= '0;
         fwd_a_q        <= 2'd0;
         fwd_b_q        <= 2'd0;
         stall_cycles_q <= '0;
         flush_events_q <= '0;
      end else begin
         ex_vld_q       <= advance;
         ex_rw_q        <= id_reg_write;
         ex_mr_q        <= id_mem_read;
         ex_rd_q        <= id_rd;
         mem_vld_q      <= ex_vld_q;
         mem_rw_q       <= ex_rw_q;
         mem_rd_q       <= ex_rd_q;
         stall_cnt_q    <= stall_cnt_d;
         fwd_a_q        <= fwd_a_d;
         fwd_b_q        <= fwd_b_d;
         stall_cycles_q <= stall_cycles_d;
         flush_events_q <= flush_events_d;
      end
   end

   // Combinational strobes are forced low while reset is held.
   always_comb begin
      stall_if     = RESET_N & stall;
      bubble_ex    = RESET_N & stall;
      flush_if_id  = RESET_N & ex_branch_taken;
      flush_id_ex  = RESET_N & ex_branch_taken;
      fwd_a_sel    = fwd_a_q;
      fwd_b_sel    = fwd_b_q;
      stall_cycles = stall_cycles_q;
      flush_events = flush_events_q;
   end

endmodule

// File: tb/tb_pipeline_hazard_unit.sv
// Bench for pipeline_hazard_unit: three instances (1, 2 and 255 load-use stalls)
// share one ID stream; forwarding expectations go through a queue and are checked
// one edge after the instruction is presented.
module tb_pipeline_hazard_unit;

   typedef struct packed {
      logic       valid;
      logic [4:0] rs1;
      logic       u1;
      logic [4:0] rs2;
      logic       u2;
      logic [4:0] rd;
      logic       rw;
      logic       mr;
   } id_t;

   typedef struct {
      string      tag;
      logic [1:0] a_fa, a_fb, b_fa, b_fb;
   } exp_t;

   localparam id_t NOP = '0;

   logic CLK = 1'b0;
   logic RESET_N;
   id_t  cur;
   logic br;

   logic        a_stall, a_bubble, a_fl_ifid, a_fl_idex;
   logic [1:0]  a_fa, a_fb;
   logic [15:0] a_sc, a_fe;
   logic        b_stall, b_bubble, b_fl_ifid, b_fl_idex;
   logic [1:0]  b_fa, b_fb;
   logic [15:0] b_sc, b_fe;
   logic        c_stall, c_bubble, c_fl_ifid, c_fl_idex;
   logic [1:0]  c_fa, c_fb;
   logic [15:0] c_sc, c_fe;

   int   n_cmp = 0;
   int   n_bad = 0;
   exp_t exp_q[$];

   always #5 CLK = ~CLK;

   pipeline_hazard_unit #(.REG_ADDR_W(5), .LOAD_USE_STALLS(1), .CNT_W(16)) u_dut_a (
      .CLK(CLK), .RESET_N(RESET_N), .id_valid(cur.valid), .id_rs1(cur.rs1), .id_rs2(cur.rs2),
      .id_uses_rs1(cur.u1), .id_uses_rs2(cur.u2), .id_rd(cur.rd), .id_reg_write(cur.rw),
      .id_mem_read(cur.mr), .ex_branch_taken(br), .stall_if(a_stall), .bubble_ex(a_bubble),
      .flush_if_id(a_fl_ifid), .flush_id_ex(a_fl_idex), .fwd_a_sel(a_fa), .fwd_b_sel(a_fb),
      .stall_cycles(a_sc), .flush_events(a_fe));

   pipeline_hazard_unit #(.REG_ADDR_W(5), .LOAD_USE_STALLS(2), .CNT_W(16)) u_dut_b (
      .CLK(CLK), .RESET_N(RESET_N), .id_valid(cur.valid), .id_rs1(cur.rs1), .id_rs2(cur.rs2),
      .id_uses_rs1(cur.u1), .id_uses_rs2(cur.u2), .id_rd(cur.rd), .id_reg_write(cur.rw),
      .id_mem_read(cur.mr), .ex_branch_taken(br), .stall_if(b_stall), .bubble_ex(b_bubble),
      .flush_if_id(b_fl_ifid), .flush_id_ex(b_fl_idex), .fwd_a_sel(b_fa), .fwd_b_sel(b_fb),
      .stall_cycles(b_sc), .flush_events(b_fe));

   pipeline_hazard_unit #(.REG_ADDR_W(5), .LOAD_USE_STALLS(255), .CNT_W(16)) u_dut_c (
      .CLK(CLK), .RESET_N(RESET_N), .id_valid(cur.valid), .id_rs1(cur.rs1), .id_rs2(cur.rs2),
      .id_uses_rs1(cur.u1), .id_uses_rs2(cur.u2), .id_rd(cur.rd), .id_reg_write(cur.rw),
      .id_mem_read(cur.mr), .ex_branch_taken(br), .stall_if(c_stall), .bubble_ex(c_bubble),
      .flush_if_id(c_fl_ifid), .flush_id_ex(c_fl_idex), .fwd_a_sel(c_fa), .fwd_b_sel(c_fb),
      .stall_cycles(c_sc), .flush_events(c_fe));

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
      end
   endtask

   function automatic id_t mk(input logic [4:0] rd, input logic rw, input logic mr,
                              input logic [4:0] rs1, input logic u1,
                              input logic [4:0] rs2, input logic u2);
      id_t t;
      t.valid = 1'b1;
      t.rd    = rd;
      t.rw    = rw;
      t.mr    = mr;
      t.rs1   = rs1;
      t.u1    = u1;
      t.rs2   = rs2;
      t.u2    = u2;
      return t;
   endfunction

   task automatic push_fwd(input string tag, input logic [1:0] afa, input logic [1:0] afb,
                           input logic [1:0] bfa, input logic [1:0] bfb);
      exp_t e;
      e.tag  = tag;
      e.a_fa = afa;
      e.a_fb = afb;
      e.b_fa = bfa;
      e.b_fb = bfb;
      exp_q.push_back(e);
   endtask

   // One cycle: after the edge, score the selects registered by it, then present new ID.
   task automatic step(input id_t ins, input logic b);
      exp_t e;
      @(posedge CLK);
      #1;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check_eq({e.tag, "/a_fwd_a"}, 32'(a_fa), 32'(e.a_fa));
         check_eq({e.tag, "/a_fwd_b"}, 32'(a_fb), 32'(e.a_fb));
         check_eq({e.tag, "/b_fwd_a"}, 32'(b_fa), 32'(e.b_fa));
         check_eq({e.tag, "/b_fwd_b"}, 32'(b_fb), 32'(e.b_fb));
      end
      cur = ins;
      br  = b;
      #1;
   endtask

   task automatic chk_stall(input string tag, input logic ea, input logic eb);
      check_eq({tag, "/a_stall_if"}, 32'(a_stall), 32'(ea));
      check_eq({tag, "/a_bubble_ex"}, 32'(a_bubble), 32'(ea));
      check_eq({tag, "/b_stall_if"}, 32'(b_stall), 32'(eb));
      check_eq({tag, "/b_bubble_ex"}, 32'(b_bubble), 32'(eb));
   endtask

   task automatic chk_flush(input string tag, input logic ef);
      check_eq({tag, "/a_flush_if_id"}, 32'(a_fl_ifid), 32'(ef));
      check_eq({tag, "/a_flush_id_ex"}, 32'(a_fl_idex), 32'(ef));
      check_eq({tag, "/b_flush_if_id"}, 32'(b_fl_ifid), 32'(ef));
      check_eq({tag, "/b_flush_id_ex"}, 32'(b_fl_idex), 32'(ef));
   endtask

   task automatic chk_all_zero(input string tag);
      chk_stall(tag, 1'b0, 1'b0);
      chk_flush(tag, 1'b0);
      check_eq({tag, "/a_fwd_a"}, 32'(a_fa), 32'd0);
      check_eq({tag, "/a_fwd_b"}, 32'(a_fb), 32'd0);
      check_eq({tag, "/b_fwd_a"}, 32'(b_fa), 32'd0);
      check_eq({tag, "/b_fwd_b"}, 32'(b_fb), 32'd0);
      check_eq({tag, "/a_stall_cycles"}, 32'(a_sc), 32'd0);
      check_eq({tag, "/a_flush_events"}, 32'(a_fe), 32'd0);
      check_eq({tag, "/b_stall_cycles"}, 32'(b_sc), 32'd0);
      check_eq({tag, "/b_flush_events"}, 32'(b_fe), 32'd0);
   endtask

   // Three empty slots retire everything from the scoreboard.
   task automatic drain();
      repeat (3) begin
         step(NOP, 1'b0);
         chk_stall("drain", 1'b0, 1'b0);
         push_fwd("drain", 2'd0, 2'd0, 2'd0, 2'd0);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      RESET_N = 1'b0;
      cur     = NOP;
      br      = 1'b1;
      #3;
      chk_all_zero("reset");
      repeat (2) @(posedge CLK);
      #1;
      br      = 1'b0;
      RESET_N = 1'b1;

      // add x1; add x2,x1,x3 -> EX forward on operand A
      step(mk(5'd1, 1, 0, 5'd8, 1, 5'd9, 1), 1'b0);
      chk_stall("s1_add_x1", 1'b0, 1'b0);
      push_fwd("s1_add_x1", 2'd0, 2'd0, 2'd0, 2'd0);
      step(mk(5'd2, 1, 0, 5'd1, 1, 5'd3, 1), 1'b0);
      chk_stall("s1_add_x2", 1'b0, 1'b0);
      push_fwd("s1_fwd_ex", 2'd1, 2'd0, 2'd1, 2'd0);
      step(NOP, 1'b0);
      push_fwd("s1_nop", 2'd0, 2'd0, 2'd0, 2'd0);

      // add x1; addi x0,x0,1; sub x4,x3,x1 -> MEM forward on operand B
      step(mk(5'd1, 1, 0, 5'd8, 1, 5'd9, 1), 1'b0);
      push_fwd("s2_add_x1", 2'd0, 2'd0, 2'd0, 2'd0);
      step(mk(5'd0, 1, 0, 5'd0, 1, 5'd0, 0), 1'b0);
      push_fwd("s2_addi_x0", 2'd0, 2'd0, 2'd0, 2'd0);
      step(mk(5'd4, 1, 0, 5'd3, 1, 5'd1, 1), 1'b0);
      chk_stall("s2_sub", 1'b0, 1'b0);
      push_fwd("s2_fwd_mem", 2'd0, 2'd2, 2'd0, 2'd2);
      drain();

      // addi x0,x0,1; add x7,x0,x0 -> x0 never hits
      step(mk(5'd0, 1, 0, 5'd0, 1, 5'd0, 0), 1'b0);
      push_fwd("s3_addi_x0", 2'd0, 2'd0, 2'd0, 2'd0);
      step(mk(5'd7, 1, 0, 5'd0, 1, 5'd0, 1), 1'b0);
      chk_stall("s3_add_x7", 1'b0, 1'b0);
      push_fwd("s3_x0", 2'd0, 2'd0, 2'd0, 2'd0);
      drain();

      // lw x5; add x6,x5,x5 held in ID: 1 stall on a, 2 stalls on b
      step(mk(5'd5, 1, 1, 5'd8, 1, 5'd0, 0), 1'b0);
      chk_stall("s4_lw", 1'b0, 1'b0);
      push_fwd("s4_lw", 2'd0, 2'd0, 2'd0, 2'd0);
      step(mk(5'd6, 1, 0, 5'd5, 1, 5'd5, 1), 1'b0);
      chk_stall("s4_c1", 1'b1, 1'b1);
      push_fwd("s4_c1", 2'd0, 2'd0, 2'd0, 2'd0);
      step(mk(5'd6, 1, 0, 5'd5, 1, 5'd5, 1), 1'b0);
      chk_stall("s4_c2", 1'b0, 1'b1);
      push_fwd("s4_c2", 2'd2, 2'd2, 2'd0, 2'd0);
      step(mk(5'd6, 1, 0, 5'd5, 1, 5'd5, 1), 1'b0);
      chk_stall("s4_c3", 1'b0, 1'b0);
      check_eq("s4_a_stall_cycles", 32'(a_sc), 32'd1);
      check_eq("s4_b_stall_cycles", 32'(b_sc), 32'd2);
      push_fwd("s4_c3", 2'd0, 2'd0, 2'd0, 2'd0);
      drain();

      // lw x5; add x6,x5 with a taken branch in the would-be stall cycle
      step(mk(5'd5, 1, 1, 5'd8, 1, 5'd0, 0), 1'b0);
      push_fwd("s5_lw", 2'd0, 2'd0, 2'd0, 2'd0);
      step(mk(5'd6, 1, 0, 5'd5, 1, 5'd0, 0), 1'b1);
      chk_stall("s5_br", 1'b0, 1'b0);
      chk_flush("s5_br", 1'b1);
      push_fwd("s5_br", 2'd0, 2'd0, 2'd0, 2'd0);
      step(NOP, 1'b0);
      chk_stall("s5_after", 1'b0, 1'b0);
      chk_flush("s5_after", 1'b0);
      check_eq("s5_a_flush_events", 32'(a_fe), 32'd1);
      check_eq("s5_b_flush_events", 32'(b_fe), 32'd1);
      check_eq("s5_a_stall_cycles", 32'(a_sc), 32'd1);
      check_eq("s5_b_stall_cycles", 32'(b_sc), 32'd2);
      push_fwd("s5_after", 2'd0, 2'd0, 2'd0, 2'd0);
      drain();

      // Reset asserted in the middle of a load-use stall
      step(mk(5'd5, 1, 1, 5'd8, 1, 5'd0, 0), 1'b0);
      push_fwd("s6_lw", 2'd0, 2'd0, 2'd0, 2'd0);
      step(mk(5'd6, 1, 0, 5'd5, 1, 5'd5, 1), 1'b0);
      chk_stall("s6_lu", 1'b1, 1'b1);
      push_fwd("s6_lu", 2'd0, 2'd0, 2'd0, 2'd0);
      #2;
      RESET_N = 1'b0;
      #1;
      chk_all_zero("s6_in_reset");
      step(NOP, 1'b0);
      #1;
      RESET_N = 1'b1;
      step(mk(6'd6, 1, 0, 5'd5, 1, 5'd5, 1), 1'b0);
      chk_stall("s6_post", 1'b0, 1'b0);
      check_eq("s6_post_a_stall_cycles", 32'(a_sc), 32'd0);
      push_fwd("s6_post", 2'd0, 2'd0, 2'd0, 2'd0);
      drain();
      step(NOP, 1'b0);

      // Back-to-back self-dependent loads keep the 255-stall instance nearly always stalled
      RESET_N = 1'b0;
      #1;
      RESET_N = 1'b1;
      cur = mk(5'd5, 1, 1, 5'd5, 1, 5'd0, 0);
      repeat (65900) @(posedge CLK);
      #1;
      check_eq("s7_c_stall_cycles_sat", 32'(c_sc), 32'hFFFF);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
